// File: rtl/instr_encoder_if.sv
// Request bus (instruction class + fields) and instruction-memory write port of instr_encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              i_valid;
    logic              o_ready;
    logic [3:0]        i_kind;
    logic [4:0]        i_rs;
    logic [4:0]        i_rt;
    logic [4:0]        i_rd;
    logic [4:0]        i_shamt;
    logic [5:0]        i_funct;
    logic [15:0]       i_imm;
    logic [25:0]       i_target;
    logic              o_we;
    logic [ADDR_W-1:0] o_addr;
    logic [31:0]       o_data;

    modport master (
        output i_valid, i_kind, i_rs, i_rt, i_rd, i_shamt, i_funct, i_imm, i_target,
        input  o_ready, o_we, o_addr, o_data
    );

    modport slave (
        input  i_valid, i_kind, i_rs, i_rt, i_rd, i_shamt, i_funct, i_imm, i_target,
        output o_ready, o_we, o_addr, o_data
    );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder/loader: accept at edge N, imem write pulse in cycle N+1, ready again in N+2.
// Backpressure: o_ready low during WRITE, while full, or while i_restart is asserted.
module instr_encoder #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_restart,
    instr_encoder_if.slave  bus,
    output logic [ADDR_W:0] o_count,
    output logic            o_err,
    output logic            o_full
);
    localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic              r_full;

    logic              w_ready;
    logic              w_legal;
    logic [5:0]        w_op;
    logic [31:0]       w_data;
    logic [ADDR_W:0]   w_count_nxt;

    always_comb begin
        w_legal = 1'b1;
        w_op    = 6'b000000;
        case (bus.i_kind)
            4'd0:    w_op = 6'b000000;
            4'd1:    w_op = 6'b001000;
            4'd2:    w_op = 6'b001001;
            4'd3:    w_op = 6'b001010;
            4'd4:    w_op = 6'b001100;
            4'd5:    w_op = 6'b001101;
            4'd6:    w_op = 6'b001110;
            4'd7:    w_op = 6'b100011;
            4'd8:    w_op = 6'b101011;
            4'd9:    w_op = 6'b000100;
            4'd10:   w_op = 6'b000101;
            4'd11:   w_op = 6'b000010;
            default: w_legal = 1'b0;
        endcase
    end

    // R-type and jump have their own layouts; every other legal class is {op, rs, rt, imm}.
    always_comb begin
        w_data = {w_op, bus.i_rs, bus.i_rt, bus.i_imm};
        if (bus.i_kind == 4'd0)
            w_data = {6'b000000, bus.i_rs, bus.i_rt, bus.i_rd, bus.i_shamt, bus.i_funct};
        else if (bus.i_kind == 4'd11)
            w_data = {6'b000010, bus.i_target};
    end

    assign w_ready     = (r_state == S_IDLE) && !r_full && !i_restart;
    assign w_count_nxt = r_count + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_ptr   <= BASE;
            r_addr  <= BASE;
            r_data  <= 32'd0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
        end else if (i_restart) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_ptr   <= BASE;
            r_addr  <= BASE;
            r_count <= '0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid && w_ready) begin
                        if (w_legal) begin
                            r_addr  <= r_ptr;
                            r_data  <= w_data;
                            r_we    <= 1'b1;
                            r_state <= S_WRITE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_we    <= 1'b0;
                    r_ptr   <= r_ptr + 1'b1;
                    r_count <= w_count_nxt;
                    r_full  <= (w_count_nxt == FULL_CNT);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Restart must kill a write already on the bus in the same cycle.
    assign bus.o_we    = r_we && !i_restart;
    assign bus.o_ready = w_ready;
    assign bus.o_addr  = r_addr;
    assign bus.o_data  = r_data;
    assign o_count     = r_count;
    assign o_err       = r_err;
    assign o_full      = r_full;
endmodule
